// File: rtl/wb_ram_32_lane_controller.sv
// rtl/wb_ram_32_lane_controller.sv - Wishbone slave front end for a 32-bit RAM built from four byte lanes
// Optional incrementing/wrapping burst support is compiled in with `define WB_RAM_32_BURST_EN.
module wb_ram_32_lane_controller #(
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  input  logic [2:0]            wb_cti_i,
  input  logic [1:0]            wb_bte_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic [31:0]           wb_dat_o,
  output logic [ADDR_WIDTH-3:0] ram_addr_o,
  output logic [3:0]            ram_we_o,
  output logic [31:0]           ram_dat_o,
  input  logic [31:0]           ram_dat_i
);

  localparam int WORD_WIDTH = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    IDLE,
    SINGLE,
    BURST
  } state_t;

  state_t state;
  logic   req;
  logic   in_range;
  logic   accept;
  logic   unused_bits;

  assign req       = wb_cyc_i & wb_stb_i;
  assign in_range  = (wb_adr_i[31:ADDR_WIDTH] == '0);
  assign ram_dat_o = wb_dat_i;
  // Lanes have a registered address, so read data is already aligned with the ack cycle.
  assign wb_dat_o  = ram_dat_i;

`ifdef WB_RAM_32_BURST_EN
  logic [WORD_WIDTH-1:0] word_cnt;
  logic [WORD_WIDTH-1:0] step_mask;
  logic [WORD_WIDTH-1:0] cnt_next;

  assign unused_bits = &{1'b0, wb_adr_i[1:0]};
  // During a burst the lanes follow the internal counter, otherwise the bus address.
  assign ram_addr_o  = (state == BURST) ? word_cnt : wb_adr_i[ADDR_WIDTH-1:2];

  // Select which low word-address bits take part in the increment for the burst type.
  always_comb begin
    step_mask = '1;
    case (wb_bte_i)
      2'b01:   step_mask = WORD_WIDTH'(3);
      2'b10:   step_mask = WORD_WIDTH'(7);
      2'b11:   step_mask = WORD_WIDTH'(15);
      default: step_mask = '1;
    endcase
  end

  // Bits outside the mask are held; bits inside increment and wrap among themselves.
  assign cnt_next = (ram_addr_o & ~step_mask) | ((ram_addr_o + WORD_WIDTH'(1)) & step_mask);
`else
  assign unused_bits = &{1'b0, wb_adr_i[1:0], wb_cti_i, wb_bte_i};
  assign ram_addr_o  = wb_adr_i[ADDR_WIDTH-1:2];
`endif

  // A beat is accepted (and may write) only in IDLE with a legal address or in a burst beat.
  always_comb begin
    accept = 1'b0;
    if (!rst_i && req) begin
      if (state == IDLE) begin
        accept = in_range;
      end else if (state == BURST) begin
        accept = 1'b1;
      end
    end
  end

  assign ram_we_o = (accept && wb_we_i) ? wb_sel_i : 4'b0000;

  // Transaction FSM with registered ack/err; SINGLE is the one cycle that carries the final response.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
`ifdef WB_RAM_32_BURST_EN
      word_cnt <= '0;
`endif
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            state <= SINGLE;
            if (!in_range) begin
              wb_err_o <= 1'b1;
            end else begin
              wb_ack_o <= 1'b1;
`ifdef WB_RAM_32_BURST_EN
              if (wb_cti_i == 3'b010) begin
                state    <= BURST;
                word_cnt <= cnt_next;
              end
`endif
            end
          end
        end
        SINGLE: begin
          state <= IDLE;
        end
`ifdef WB_RAM_32_BURST_EN
        BURST: begin
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else if (wb_stb_i) begin
            wb_ack_o <= 1'b1;
            word_cnt <= cnt_next;
            if (wb_cti_i == 3'b111) begin
              state <= SINGLE;
            end
          end
        end
`endif
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_ram_32_lane_controller.sv
// tb/tb_wb_ram_32_lane_controller.sv - directed vector bench for wb_ram_32_lane_controller
`timescale 1ns/1ps
module tb_wb_ram_32_lane_controller;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [31:0] wb_adr_i, wb_dat_i;
  logic [3:0]  wb_sel_i;
  logic [2:0]  wb_cti_i;
  logic [1:0]  wb_bte_i;
  logic        wb_ack_o, wb_err_o;
  logic [31:0] wb_dat_o;
  logic [10:0] ram_addr_o;
  logic [3:0]  ram_we_o;
  logic [31:0] ram_dat_o;
  logic [31:0] ram_dat_i;

  int n_tests = 0;
  int n_fail  = 0;

  wb_ram_32_lane_controller #(.ADDR_WIDTH(13)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_dat_o(wb_dat_o),
    .ram_addr_o(ram_addr_o), .ram_we_o(ram_we_o), .ram_dat_o(ram_dat_o),
    .ram_dat_i(ram_dat_i)
  );

  always #5 clk_i = ~clk_i;

  // Four byte lanes sharing a registered word address
  logic [31:0] mem [0:2047];
  logic [10:0] addr_q;
  logic        clear_mem;

  always @(posedge clk_i) begin
    if (clear_mem) begin
      for (int k = 0; k < 2048; k++) mem[k] <= 32'h0;
      addr_q <= '0;
    end else begin
      for (int n = 0; n < 4; n++)
        if (ram_we_o[n]) mem[ram_addr_o][8*n +: 8] <= ram_dat_o[8*n +: 8];
      addr_q <= ram_addr_o;
    end
  end
  assign ram_dat_i = mem[addr_q];

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [3:0]  exp_we;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_idle();
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = 32'h0; wb_sel_i = 4'h0; wb_dat_i = 32'h0;
    wb_cti_i = 3'b000; wb_bte_i = 2'b00;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    v = vecs[i];
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = v.we; wb_adr_i = v.adr;
    wb_sel_i = v.sel; wb_dat_i = v.dat; wb_cti_i = 3'b000; wb_bte_i = 2'b00;
    @(negedge clk_i);
    check($sformatf("v%0d lane_we", i), 32'(ram_we_o), 32'(v.exp_we));
    check($sformatf("v%0d lane_addr", i), 32'(ram_addr_o), 32'(v.adr[12:2]));
    check($sformatf("v%0d lane_wdata", i), ram_dat_o, v.dat);
    check($sformatf("v%0d early_ack", i), 32'(wb_ack_o), 32'h0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check($sformatf("v%0d ack", i), 32'(wb_ack_o), 32'(v.exp_ack));
    check($sformatf("v%0d err", i), 32'(wb_err_o), 32'(v.exp_err));
    check($sformatf("v%0d no_rewrite", i), 32'(ram_we_o), 32'h0);
    if (!v.we && v.exp_ack) check($sformatf("v%0d rdata", i), wb_dat_o, v.exp_rd);
    @(posedge clk_i); #1;
    bus_idle();
    @(negedge clk_i);
    check($sformatf("v%0d ack_one_cycle", i), 32'({wb_ack_o, wb_err_o}), 32'h0);
  endtask

  task automatic do_read(input string name, input logic [31:0] adr, input logic [31:0] exp);
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = adr;
    wb_sel_i = 4'hF; wb_cti_i = 3'b000; wb_bte_i = 2'b00;
    @(negedge clk_i);
    check({name, " early_ack"}, 32'(wb_ack_o), 32'h0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check({name, " ack"}, 32'(wb_ack_o), 32'h1);
    check({name, " rdata"}, wb_dat_o, exp);
    @(posedge clk_i); #1;
    bus_idle();
  endtask

`ifdef WB_RAM_32_BURST_EN
  task automatic run_burst4(input string name, input logic we, input logic [31:0] adr,
                            input logic [1:0] bte, input logic [3:0][31:0] wdat,
                            input logic [3:0][10:0] eaddr, input logic [3:0][31:0] rdat);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i); #1;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr;
      wb_sel_i = 4'hF; wb_dat_i = wdat[i]; wb_bte_i = bte;
      wb_cti_i = (i == 3) ? 3'b111 : 3'b010;
      @(negedge clk_i);
      check($sformatf("%s addr%0d", name, i), 32'(ram_addr_o), 32'(eaddr[i]));
      check($sformatf("%s we%0d", name, i), 32'(ram_we_o), we ? 32'hF : 32'h0);
      check($sformatf("%s ack%0d", name, i), 32'(wb_ack_o), (i == 0) ? 32'h0 : 32'h1);
      if (!we && i > 0) check($sformatf("%s rdata%0d", name, i - 1), wb_dat_o, rdat[i-1]);
    end
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check({name, " last_ack"}, 32'(wb_ack_o), 32'h1);
    check({name, " last_no_write"}, 32'(ram_we_o), 32'h0);
    if (!we) check({name, " rdata3"}, wb_dat_o, rdat[3]);
    @(posedge clk_i); #1;
    bus_idle();
    wb_adr_i = 32'h40;
    @(negedge clk_i);
    check({name, " end_ack"}, 32'(wb_ack_o), 32'h0);
    check({name, " idle_addr"}, 32'(ram_addr_o), 32'h10);
  endtask
`endif

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0010, 4'hF, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         4'h0, 1'b1, 1'b0, 32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0010, 4'h1, 32'h0000_00AA, 4'h1, 1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0010, 4'hF, 32'h0,         4'h0, 1'b1, 1'b0, 32'hDEAD_BEAA};
    vecs[4]  = '{1'b0, 32'h0001_0000, 4'hF, 32'h0,         4'h0, 1'b0, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 32'h0001_0000, 4'hF, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'h0000_1FFC, 4'hA, 32'h1122_3344, 4'hA, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_1FFC, 4'hF, 32'h0,         4'h0, 1'b1, 1'b0, 32'h1100_3300};
    vecs[8]  = '{1'b1, 32'h0000_0020, 4'h0, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0020, 4'hF, 32'h0,         4'h0, 1'b1, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h8000_0010, 4'hF, 32'h0,         4'h0, 1'b0, 1'b1, 32'h0};

    bus_idle();
    rst_i = 1'b1;
    clear_mem = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("reset ack", 32'(wb_ack_o), 32'h0);
    check("reset err", 32'(wb_err_o), 32'h0);
    check("reset lane_we", 32'(ram_we_o), 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    clear_mem = 1'b0;

    for (int i = 0; i < 11; i++) run_vec(i);

    // Reset while a write request is on the bus: no lane write, no response
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h30;
    wb_sel_i = 4'hF; wb_dat_i = 32'h1234_5678;
    @(negedge clk_i);
    check("rst_req lane_we", 32'(ram_we_o), 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    bus_idle();
    @(negedge clk_i);
    check("rst_req ack", 32'({wb_ack_o, wb_err_o}), 32'h0);
    do_read("rst_req mem", 32'h30, 32'h0);

`ifndef WB_RAM_32_BURST_EN
    // Burst-tagged request held continuously is served as classic singles, one ack every 2 cycles
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h10;
    wb_sel_i = 4'hF; wb_cti_i = 3'b010; wb_bte_i = 2'b01;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_i);
      check($sformatf("classic ack%0d", k), 32'(wb_ack_o), (k % 2 == 1) ? 32'h1 : 32'h0);
      @(posedge clk_i); #1;
    end
    bus_idle();
    @(negedge clk_i);
    check("classic end_ack", 32'(wb_ack_o), 32'h0);
`else
    run_burst4("wrap4_wr", 1'b1, 32'h18, 2'b01,
               {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
               {11'd5, 11'd4, 11'd7, 11'd6}, {32'h0, 32'h0, 32'h0, 32'h0});
    run_burst4("wrap4_rd", 1'b0, 32'h18, 2'b01, {32'h0, 32'h0, 32'h0, 32'h0},
               {11'd5, 11'd4, 11'd7, 11'd6},
               {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
    do_read("wrap4 word4", 32'h10, 32'h3333_3333);
    run_burst4("wrap8_rd", 1'b0, 32'h1C, 2'b10, {32'h0, 32'h0, 32'h0, 32'h0},
               {11'd2, 11'd1, 11'd0, 11'd7}, {32'h0, 32'h0, 32'h0, 32'h2222_2222});
    run_burst4("wrap16_rd", 1'b0, 32'h78, 2'b11, {32'h0, 32'h0, 32'h0, 32'h0},
               {11'h11, 11'h10, 11'h1F, 11'h1E}, {32'h0, 32'h0, 32'h0, 32'h0});

    // Linear write burst across the top of memory with a two-cycle wait state
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h1FFC;
    wb_sel_i = 4'hF; wb_dat_i = 32'hA5A5_A5A5; wb_cti_i = 3'b010; wb_bte_i = 2'b00;
    @(negedge clk_i);
    check("lin beat1 addr", 32'(ram_addr_o), 32'h7FF);
    check("lin beat1 we", 32'(ram_we_o), 32'hF);
    @(posedge clk_i); #1;
    wb_stb_i = 1'b0;
    @(negedge clk_i);
    check("lin gap1 ack", 32'(wb_ack_o), 32'h1);
    check("lin gap1 we", 32'(ram_we_o), 32'h0);
    check("lin gap1 addr", 32'(ram_addr_o), 32'h0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("lin gap2 ack", 32'(wb_ack_o), 32'h0);
    check("lin gap2 we", 32'(ram_we_o), 32'h0);
    @(posedge clk_i); #1;
    wb_stb_i = 1'b1; wb_dat_i = 32'h5A5A_5A5A; wb_cti_i = 3'b111;
    @(negedge clk_i);
    check("lin beat2 ack", 32'(wb_ack_o), 32'h0);
    check("lin beat2 addr", 32'(ram_addr_o), 32'h0);
    check("lin beat2 we", 32'(ram_we_o), 32'hF);
    check("lin beat2 err", 32'(wb_err_o), 32'h0);
    @(posedge clk_i); #1;
    @(negedge clk_i);
    check("lin last ack", 32'(wb_ack_o), 32'h1);
    check("lin last we", 32'(ram_we_o), 32'h0);
    @(posedge clk_i); #1;
    bus_idle();
    @(negedge clk_i);
    check("lin end ack", 32'(wb_ack_o), 32'h0);
    do_read("lin word0", 32'h0, 32'h5A5A_5A5A);
    do_read("lin top", 32'h1FFC, 32'hA5A5_A5A5);
    do_read("lin word1", 32'h4, 32'h0);

    // Reset on the second beat of a burst aborts it
    @(posedge clk_i); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h100;
    wb_sel_i = 4'hF; wb_dat_i = 32'h0101_0101; wb_cti_i = 3'b010; wb_bte_i = 2'b00;
    @(negedge clk_i);
    check("rstb beat1 we", 32'(ram_we_o), 32'hF);
    check("rstb beat1 addr", 32'(ram_addr_o), 32'h40);
    @(posedge clk_i); #1;
    rst_i = 1'b1;
    wb_dat_i = 32'h0202_0202;
    @(negedge clk_i);
    check("rstb reset we", 32'(ram_we_o), 32'h0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    bus_idle();
    wb_adr_i = 32'h200;
    @(negedge clk_i);
    check("rstb ack", 32'({wb_ack_o, wb_err_o}), 32'h0);
    check("rstb idle_addr", 32'(ram_addr_o), 32'h80);
    check("rstb idle_we", 32'(ram_we_o), 32'h0);
    do_read("rstb word64", 32'h100, 32'h0101_0101);
    do_read("rstb word65", 32'h104, 32'h0);
`endif

    repeat (2) @(posedge clk_i);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
